// File: rtl/coin_payer.sv
// rtl/coin_payer.sv - coin bus payment initiator for the vending FSM; define COIN_PAYER_STATS_EN for coins_sent/txn_ok counters
module coin_payer #(
    parameter int AMT_W        = 4,
    parameter int GAP          = 0,
    parameter int RESP_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             pref_two,
    input  logic             product_in,
    input  logic             change_in,
    output logic [1:0]       coin,
    output logic             busy,
    output logic             done,
    output logic             paid_ok,
    output logic             change_seen,
    output logic             timeout_err,
    output logic [AMT_W-1:0] remaining
`ifdef COIN_PAYER_STATS_EN
    ,
    output logic [7:0]       coins_sent,
    output logic [7:0]       txn_ok
`endif
);

    localparam int              RC_W      = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [RC_W-1:0] RESP_LAST = RC_W'(RESP_TIMEOUT - 1);
    localparam logic [3:0]      GAP_LAST  = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT_RESP,
        S_DONE
    } state_t;

    state_t          state;
    logic            pref_q;
    logic [3:0]      gap_cnt;
    logic [RC_W-1:0] resp_cnt;
    logic [1:0]      next_coin;

    // A 2-rupee coin is only chosen when at least 2 remain, so remaining never underflows.
    function automatic logic [1:0] pick_coin(input logic two_ok, input logic [AMT_W-1:0] amt);
        if (two_ok && (amt >= AMT_W'(2))) begin
            return 2'd2;
        end
        return 2'd1;
    endfunction

    assign next_coin = pick_coin(pref_q, remaining);

    // Payment sequencer: splits the request into coins, then waits for the vend response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            coin        <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            paid_ok     <= 1'b0;
            change_seen <= 1'b0;
            timeout_err <= 1'b0;
            remaining   <= '0;
            pref_q      <= 1'b0;
            gap_cnt     <= 4'd0;
            resp_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    coin <= 2'd0;
                    busy <= 1'b0;
                    if (start && (amount != '0)) begin
                        pref_q      <= pref_two;
                        coin        <= pick_coin(pref_two, amount);
                        remaining   <= amount - AMT_W'(pick_coin(pref_two, amount));
                        paid_ok     <= 1'b0;
                        change_seen <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (product_in) begin
                        // Vending FSM reached price early: stop and keep the unsent amount.
                        coin        <= 2'd0;
                        paid_ok     <= 1'b1;
                        change_seen <= change_in;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else if (remaining != '0) begin
                        if (GAP == 0) begin
                            coin      <= next_coin;
                            remaining <= remaining - AMT_W'(next_coin);
                        end else begin
                            coin    <= 2'd0;
                            gap_cnt <= 4'd0;
                            state   <= S_GAP;
                        end
                    end else begin
                        coin     <= 2'd0;
                        resp_cnt <= '0;
                        state    <= S_WAIT_RESP;
                    end
                end
                S_GAP: begin
                    if (product_in) begin
                        paid_ok     <= 1'b1;
                        change_seen <= change_in;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else if (gap_cnt == GAP_LAST) begin
                        coin      <= next_coin;
                        remaining <= remaining - AMT_W'(next_coin);
                        state     <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_WAIT_RESP: begin
                    // Product on the timeout edge still counts as a successful vend.
                    if (product_in) begin
                        paid_ok     <= 1'b1;
                        change_seen <= change_in;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else if (resp_cnt == RESP_LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        resp_cnt <= resp_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    coin  <= 2'd0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COIN_PAYER_STATS_EN
    // Lifetime counters: every cycle with a nonzero coin is one coin driven; every paid DONE is one good transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            coins_sent <= 8'd0;
            txn_ok     <= 8'd0;
        end else begin
            if ((coin != 2'd0) && (coins_sent != 8'hff)) begin
                coins_sent <= coins_sent + 8'd1;
            end
            if (done && paid_ok && (txn_ok != 8'hff)) begin
                txn_ok <= txn_ok + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coin_payer.sv
// tb/tb_coin_payer.sv - randomized self-checking bench for coin_payer (GAP=0 and GAP=2 instances)
module tb_coin_payer;

    localparam int AMT_W = 4;
    localparam int GAP1  = 2;
    localparam int RT    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_s      [2];
    logic             start_s    [2];
    logic [AMT_W-1:0] amount_s   [2];
    logic             pref_s     [2];
    logic             product_s  [2];
    logic             change_s   [2];
    logic [1:0]       coin_s     [2];
    logic             busy_s     [2];
    logic             done_s     [2];
    logic             paid_s     [2];
    logic             chg_seen_s [2];
    logic             to_s       [2];
    logic [AMT_W-1:0] rem_s      [2];
`ifdef COIN_PAYER_STATS_EN
    logic [7:0]       coins_s    [2];
    logic [7:0]       txn_s      [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        coin_payer #(
            .AMT_W(AMT_W),
            .GAP((g == 0) ? 0 : GAP1),
            .RESP_TIMEOUT(RT)
        ) u_dut (
            .clk(clk),
            .rst(rst_s[g]),
            .start(start_s[g]),
            .amount(amount_s[g]),
            .pref_two(pref_s[g]),
            .product_in(product_s[g]),
            .change_in(change_s[g]),
            .coin(coin_s[g]),
            .busy(busy_s[g]),
            .done(done_s[g]),
            .paid_ok(paid_s[g]),
            .change_seen(chg_seen_s[g]),
            .timeout_err(to_s[g]),
            .remaining(rem_s[g])
`ifdef COIN_PAYER_STATS_EN
            ,
            .coins_sent(coins_s[g]),
            .txn_ok(txn_s[g])
`endif
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    int last_rem  [2];
    int last_paid [2];
    int last_chg  [2];
    int last_to   [2];
    int exp_coins [2];
    int exp_txn   [2];

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : GAP1;
    endfunction

    task automatic clear_model(input int d);
        last_rem[d]  = 0;
        last_paid[d] = 0;
        last_chg[d]  = 0;
        last_to[d]   = 0;
        exp_coins[d] = 0;
        exp_txn[d]   = 0;
    endtask

    // Idle cycle: bus quiet, not busy, status held from the last transaction.
    task automatic check_idle(input int d);
        check("idle_coin", coin_s[d], 0);
        check("idle_busy", busy_s[d], 0);
        check("idle_done", done_s[d], 0);
        check("idle_rem", rem_s[d], last_rem[d]);
        check("idle_paid", paid_s[d], last_paid[d]);
        check("idle_chg", chg_seen_s[d], last_chg[d]);
        check("idle_to", to_s[d], last_to[d]);
`ifdef COIN_PAYER_STATS_EN
        check("coins_sent", coins_s[d], exp_coins[d]);
        check("txn_ok", txn_s[d], exp_txn[d]);
`endif
    endtask

    // One payment; precondition: at a negedge of an idle cycle. p_in<0 picks a random product cycle.
    task automatic run_txn(input int d, input int amt, input bit pref, input int p_in, input bit chg);
        int  coins[$];
        int  trace[$];
        int  rem, v, len, p, done_idx, sent, nsent, ecoin;
        bit  paid;
        rem = amt;
        while (rem > 0) begin
            v = (pref && rem >= 2) ? 2 : 1;
            coins.push_back(v);
            rem -= v;
        end
        foreach (coins[k]) begin
            trace.push_back(coins[k]);
            if (k < coins.size() - 1) begin
                for (int j = 0; j < gap_of(d); j++) trace.push_back(0);
            end
        end
        len      = trace.size();
        p        = (p_in < 0) ? int'($urandom_range(0, len + RT + 1)) : p_in;
        paid     = (p < len + RT);
        done_idx = paid ? p + 1 : len + RT;
        sent     = 0;
        nsent    = 0;
        start_s[d]   = 1'b1;
        amount_s[d]  = AMT_W'(amt);
        pref_s[d]    = pref;
        product_s[d] = 1'b0;
        change_s[d]  = 1'b0;
        for (int i = 0; i <= done_idx; i++) begin
            @(negedge clk);
            ecoin = (i < len && (!paid || i <= p)) ? trace[i] : 0;
            sent += ecoin;
            if (ecoin != 0) nsent++;
            check("coin", coin_s[d], ecoin);
            check("busy", busy_s[d], 1);
            check("done", done_s[d], int'(i == done_idx));
            if (i == done_idx) begin
                check("paid_ok", paid_s[d], int'(paid));
                check("change_seen", chg_seen_s[d], int'(paid && chg));
                check("timeout_err", to_s[d], int'(!paid));
                check("remaining", rem_s[d], amt - sent);
            end
            start_s[d]   = ($urandom_range(0, 3) == 0);
            amount_s[d]  = AMT_W'($urandom_range(0, 15));
            pref_s[d]    = 1'($urandom_range(0, 1));
            product_s[d] = paid && (i == p);
            change_s[d]  = (i == p) ? chg : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start_s[d]   = 1'b0;
        product_s[d] = 1'b0;
        change_s[d]  = 1'b0;
        last_rem[d]  = amt - sent;
        last_paid[d] = int'(paid);
        last_chg[d]  = int'(paid && chg);
        last_to[d]   = int'(!paid);
        exp_coins[d] = (exp_coins[d] + nsent > 255) ? 255 : exp_coins[d] + nsent;
        if (paid) exp_txn[d] = (exp_txn[d] + 1 > 255) ? 255 : exp_txn[d] + 1;
        check_idle(d);
    endtask

    task automatic zero_start(input int d);
        start_s[d]  = 1'b1;
        amount_s[d] = '0;
        pref_s[d]   = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_s[d] = 1'b0;
        check_idle(d);
    endtask

    // Reset on the second coin of a 3-rupee 1-coin payment (GAP=0 instance).
    task automatic reset_mid();
        start_s[0]  = 1'b1;
        amount_s[0] = AMT_W'(3);
        pref_s[0]   = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        check("rst_coin0", coin_s[0], 1);
        @(negedge clk);
        check("rst_coin1", coin_s[0], 1);
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        clear_model(0);
        check_idle(0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; start_s[d] = 1'b0; amount_s[d] = '0; pref_s[d] = 1'b0;
            product_s[d] = 1'b0; change_s[d] = 1'b0;
            clear_model(d);
        end
        repeat (3) @(negedge clk);
        check_idle(0);
        check_idle(1);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        run_txn(0, 3, 1'b0, 3, 1'b0);
        run_txn(1, 4, 1'b1, 4, 1'b1);
        run_txn(0, 5, 1'b1, 1, 1'b0);
        run_txn(0, 2, 1'b0, 100, 1'b0);
        run_txn(0, 3, 1'b1, 2 + RT - 1, 1'b1);
        run_txn(1, 5, 1'b1, 2, 1'b0);
        reset_mid();
        run_txn(0, 1, 1'b0, -1, 1'b1);
        zero_start(0);
        zero_start(1);
        run_txn(1, 15, 1'b0, -1, 1'b0);

        for (int n = 0; n < 160; n++) begin
            int d;
            int amt;
            d   = int'($urandom_range(0, 1));
            amt = int'($urandom_range(0, 15));
            if (amt == 0) zero_start(d);
            else run_txn(d, amt, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_payer.md
Name: coin_payer

Overview:
- Payment initiator that drives the 2-bit coin bus of the vending FSM and watches its product/change responses.
- Takes a payment request (amount in rupees) and breaks it into 1- and 2-rupee coin codes, one coin per cycle with an optional idle gap.
- Reports done, success, change-returned and timeout status to the customer-side controller or testbench.

Parameters:
- AMT_W, 4, width of amount and remaining.
- GAP, 0, idle cycles (coin=0) inserted between consecutive coins; 0..15.
- RESP_TIMEOUT, 4, cycles to wait for product after the last coin before flagging timeout; >=1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- amount  input  AMT_W  rupees to pay; sampled with start.
- pref_two  input  1  1 = use 2-rupee coins while remaining>=2; 0 = 1-rupee coins only. Sampled with start.
- product_in  input  1  product indication from the vending FSM.
- change_in  input  1  change indication from the vending FSM.
- coin  output  2  coin code: 0 none, 1 one rupee, 2 two rupees. Code 3 is never driven.
- busy  output  1  high from the accept edge until DONE exits.
- done  output  1  one-cycle completion pulse.
- paid_ok  output  1  product observed in the last transaction.
- change_seen  output  1  change_in was high together with product_in.
- timeout_err  output  1  no product within RESP_TIMEOUT cycles.
- remaining  output  AMT_W  rupees not yet sent.

Behaviour:
- All outputs are registered. On rst, all outputs are 0 and state=IDLE. This holds regardless of current state: a reset mid-payment forces coin=0 on the next cycle and discards the transaction with no done pulse.
- States: IDLE, SEND, GAP, WAIT_RESP, DONE.
- IDLE: coin=0, busy=0.
  - start=1 with amount!=0: accept. On that edge:
    - latch pref_two;
    - load coin with the first coin value v: 2 if pref_two and amount>=2, else 1;
    - set remaining=amount-v;
    - clear paid_ok, change_seen, timeout_err;
    - set busy=1.
  - start with amount==0 is ignored: stay in IDLE, no done pulse.
- Coin latency: the first coin is visible in the cycle immediately after the accept edge. Each coin is held for exactly one cycle.
- SEND (a coin is on the bus this cycle):
  - remaining!=0 and GAP==0: next edge loads the next coin and decrements remaining; stay in SEND.
  - remaining!=0 and GAP>0: next edge sets coin=0 and enters GAP for exactly GAP cycles, then loads the next coin and returns to SEND.
  - remaining==0: next edge sets coin=0, clears the response counter, enters WAIT_RESP.
- Early vend: product_in=1 sampled in SEND or GAP means the vending FSM reached price before all coins were sent.
  - Stop sending: coin=0 next cycle.
  - Set paid_ok=1 and change_seen=change_in; enter DONE.
  - remaining keeps the unsent amount.
- WAIT_RESP: coin=0; the counter increments each cycle.
  - product_in=1: set paid_ok=1, change_seen=change_in; enter DONE.
  - Otherwise, when counter reaches RESP_TIMEOUT-1 without product: set timeout_err=1; enter DONE.
  - If product_in and timeout coincide on the same edge, product wins.
- DONE: done=1 for one cycle, busy stays 1; next edge goes to IDLE with busy=0.
- Status outputs (paid_ok, change_seen, timeout_err, remaining) hold until the next accepted start or rst.
- start while busy=1 is ignored, including start in the DONE cycle.
- change_in without product_in is ignored.
- Arithmetic: remaining never underflows, because a 2-rupee coin is chosen only when remaining>=2.
- Back-to-back transactions: start may be asserted in the first IDLE cycle after DONE.

Optional Feature:
- Macro: COIN_PAYER_STATS_EN.
- Defined:
  - adds output coins_sent (8 bits): total coins driven, saturating at 255;
  - adds output txn_ok (8 bits): count of DONE with paid_ok=1, saturating at 255;
  - both counters are cleared by rst only.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- amount=3, pref_two=0, GAP=0; product_in high in the cycle after the third coin -> coin sequence 1,1,1 on consecutive cycles; done 2 cycles after the last coin; paid_ok=1, remaining=0, timeout_err=0.
- amount=4, pref_two=1, GAP=2; product_in and change_in high 1 cycle after the 2nd coin -> coin sequence 2,0,0,2; paid_ok=1, change_seen=1.
- amount=5, pref_two=1; product_in high during the cycle the second coin is driven -> coins 2,2, then coin=0; paid_ok=1, remaining=1; third coin never sent.
- amount=2, pref_two=0, product_in held 0 -> coins 1,1; timeout_err=1 and done pulse after exactly RESP_TIMEOUT=4 WAIT_RESP cycles; paid_ok=0.
- rst asserted on the second coin cycle of amount=3 -> coin=0, busy=0 the next cycle, no done; a subsequent start with amount=1 sends a single coin=1.
- start with amount=0, and start pulses while busy -> no state change, no extra coins; with COIN_PAYER_STATS_EN defined, coins_sent and txn_ok are unchanged by these pulses.
